// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO: word address, select,
// active-low write strobe and the 32-bit data paths.
interface pio_in_edge_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pio_in_edge_irq.sv
// Input PIO with per-bit synchroniser, optional debounce filter, selectable
// edge capture (write-1-to-clear) and a masked level interrupt.

// One input bit: two-flop synchroniser, debounce filter and the previous
// filtered value used for edge detection.
module pio_in_edge_irq_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic filtered,
    output logic prev
);
    logic s1, s2;

    // Two-flop synchroniser; the raw pin never reaches any logic beyond s1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= RESET_LEVEL;
            s2 <= RESET_LEVEL;
        end else begin
            s1 <= pin;
            s2 <= s1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: the filtered bit just follows the synchroniser.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) filtered <= RESET_LEVEL;
                else          filtered <= s2;
            end
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt;

            // Count consecutive cycles that s2 disagrees with the filtered
            // value; accept the new level once it has held long enough.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt      <= '0;
                    filtered <= RESET_LEVEL;
                end else if (s2 == filtered) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt      <= '0;
                    filtered <= s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

    // Previous filtered value, the reference for rise/fall detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= RESET_LEVEL;
        else          prev <= filtered;
    end
endmodule

module pio_in_edge_irq #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int RESET_LEVEL     = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_in_edge_irq_if.slave     bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);
    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_MASK = 3'd2;
    localparam logic [2:0] A_EDGE = 3'd3;

    logic [WIDTH-1:0] filtered, prev, rise, fall, edge_evt;
    logic [WIDTH-1:0] edge_capture, irq_mask, w1c;
    logic [31:0]      rd_next;
    logic             wr;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata carry meaning.
    assign unused_wdata = ^bus.writedata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        pio_in_edge_irq_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL != 0)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin      (in_port[g]),
            .filtered (filtered[g]),
            .prev     (prev[g])
        );
    end

    assign rise = filtered & ~prev;
    assign fall = ~filtered & prev;
    assign wr   = bus.chipselect && !bus.write_n;
    assign w1c  = (wr && bus.address == A_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

    // Pick which transitions count as events.
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_evt = rise;
            1:       edge_evt = fall;
            default: edge_evt = rise | fall;
        endcase
    end

    // Sticky capture; a new edge beats a simultaneous clear so none is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_capture <= '0;
        else          edge_capture <= (edge_capture & ~w1c) | edge_evt;
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        irq_mask <= '0;
        else if (wr && bus.address == A_MASK) irq_mask <= bus.writedata[WIDTH-1:0];
    end

    // Read mux; unmapped addresses and unused upper bits read zero.
    always_comb begin
        rd_next = '0;
        case (bus.address)
            A_DATA:  rd_next[WIDTH-1:0] = filtered;
            A_MASK:  rd_next[WIDTH-1:0] = irq_mask;
            A_EDGE:  rd_next[WIDTH-1:0] = edge_capture;
            default: rd_next = '0;
        endcase
    end

    // Registered read data, refreshed whenever the slave is selected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            bus.readdata <= '0;
        else if (bus.chipselect) bus.readdata <= rd_next;
    end

    // Registered level interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= |(edge_capture & irq_mask);
    end
endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: four instances (rising/bypass, falling,
// any-edge, rising with 8-cycle debounce) share one bus driver; a
// cycle-level reference model is compared against every instance each cycle.
module tb_pio_in_edge_irq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic        cs = 1'b0;
    logic        wn = 1'b1;
    logic [31:0] wd = 32'd0;
    logic [9:0]  pin [4];
    logic [31:0] dut_rd [4];
    logic [3:0]  dut_irq;

    int n_cmp = 0;
    int n_err = 0;

    int   P_EDGE [4] = '{0, 1, 2, 0};
    int   P_DEB  [4] = '{0, 0, 0, 8};
    logic P_RL   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    pio_in_edge_irq_if bus0 ();
    pio_in_edge_irq_if bus1 ();
    pio_in_edge_irq_if bus2 ();
    pio_in_edge_irq_if bus3 ();

    assign bus0.address = addr; assign bus0.chipselect = cs; assign bus0.write_n = wn; assign bus0.writedata = wd;
    assign bus1.address = addr; assign bus1.chipselect = cs; assign bus1.write_n = wn; assign bus1.writedata = wd;
    assign bus2.address = addr; assign bus2.chipselect = cs; assign bus2.write_n = wn; assign bus2.writedata = wd;
    assign bus3.address = addr; assign bus3.chipselect = cs; assign bus3.write_n = wn; assign bus3.writedata = wd;
    assign dut_rd[0] = bus0.readdata;
    assign dut_rd[1] = bus1.readdata;
    assign dut_rd[2] = bus2.readdata;
    assign dut_rd[3] = bus3.readdata;

    pio_in_edge_irq #(.WIDTH(10), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .RESET_LEVEL(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(pin[0]), .irq(dut_irq[0]));
    pio_in_edge_irq #(.WIDTH(10), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1), .RESET_LEVEL(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(pin[1]), .irq(dut_irq[1]));
    pio_in_edge_irq #(.WIDTH(10), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .RESET_LEVEL(1)) u_any (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(pin[2]), .irq(dut_irq[2]));
    pio_in_edge_irq #(.WIDTH(10), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0), .RESET_LEVEL(0)) u_deb (
        .clk(clk), .reset_n(reset_n), .bus(bus3), .in_port(pin[3]), .irq(dut_irq[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pin samples delayed by two clocks, a per-bit run length of how long
    // the synchronised level has disagreed with the accepted level, and the
    // register file as the bus sees it.
    logic [9:0]  m_d1 [4], m_d2 [4], m_filt [4], m_prev [4], m_cap [4], m_mask [4];
    int          m_run [4][10];
    logic [31:0] m_rd [4];
    logic        m_irq [4];

    task automatic model_step(input int k);
        logic [9:0] evt, clr, nf, rl;
        logic       nirq;
        rl = P_RL[k] ? 10'h3FF : 10'h000;
        if (!reset_n) begin
            m_d1[k] = rl; m_d2[k] = rl; m_filt[k] = rl; m_prev[k] = rl;
            m_cap[k] = '0; m_mask[k] = '0; m_rd[k] = '0; m_irq[k] = 1'b0;
            for (int i = 0; i < 10; i++) m_run[k][i] = 0;
            return;
        end
        case (P_EDGE[k])
            0:       evt = m_filt[k] & ~m_prev[k];
            1:       evt = ~m_filt[k] & m_prev[k];
            default: evt = m_filt[k] ^ m_prev[k];
        endcase
        nirq = (m_cap[k] & m_mask[k]) != 0;
        if (cs) begin
            case (addr)
                3'd0:    m_rd[k] = {22'd0, m_filt[k]};
                3'd2:    m_rd[k] = {22'd0, m_mask[k]};
                3'd3:    m_rd[k] = {22'd0, m_cap[k]};
                default: m_rd[k] = 32'd0;
            endcase
        end
        clr = (cs && !wn && addr == 3'd3) ? wd[9:0] : 10'd0;
        m_cap[k] = (m_cap[k] & ~clr) | evt;
        if (cs && !wn && addr == 3'd2) m_mask[k] = wd[9:0];
        nf = m_filt[k];
        for (int i = 0; i < 10; i++) begin
            if (P_DEB[k] == 0) nf[i] = m_d2[k][i];
            else if (m_d2[k][i] != m_filt[k][i]) begin
                m_run[k][i] = m_run[k][i] + 1;
                if (m_run[k][i] == P_DEB[k]) begin
                    nf[i] = m_d2[k][i];
                    m_run[k][i] = 0;
                end
            end else m_run[k][i] = 0;
        end
        m_prev[k] = m_filt[k];
        m_filt[k] = nf;
        m_d2[k]   = m_d1[k];
        m_d1[k]   = pin[k];
        m_irq[k]  = nirq;
    endtask

    // Single compare process: step the model on each edge, check shortly after.
    always begin
        @(posedge clk);
        for (int k = 0; k < 4; k++) model_step(k);
        #2;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("model_rd[%0d]", k), dut_rd[k], m_rd[k]);
            check($sformatf("model_irq[%0d]", k), {31'd0, dut_irq[k]}, {31'd0, m_irq[k]});
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] rdv [4];

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        addr = a; wd = d; cs = 1'b1; wn = 1'b0;
        @(negedge clk);
        cs = 1'b0; wn = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a);
        addr = a; cs = 1'b1; wn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) rdv[k] = dut_rd[k];
        cs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        pin[0] = 10'h000; pin[1] = 10'h3FF; pin[2] = 10'h3FF; pin[3] = 10'h000;
        idle(3);
        check("rst_irq", {28'd0, dut_irq}, 32'd0);
        check("rst_rd_rise", dut_rd[0], 32'd0);

        // Reset release with inputs already at their idle levels.
        reset_n = 1'b1;
        idle(4);
        bus_read(3'd0); check("rst_data_fall", rdv[1], 32'h3FF); check("rst_data_rise", rdv[0], 32'h0);
        bus_read(3'd2); check("rst_mask_fall", rdv[1], 32'h0);
        bus_read(3'd3); check("rst_cap_fall", rdv[1], 32'h0);
        check("rst_irq_after", {28'd0, dut_irq}, 32'd0);

        // Rising capture, masked interrupt, W1C.
        pin[0] = 10'h005;
        idle(5);
        bus_read(3'd3); check("rise_cap", rdv[0], 32'h005);
        check("rise_irq_masked", {31'd0, dut_irq[0]}, 32'd0);
        bus_write(3'd2, 32'h004);
        idle(1); check("rise_irq_on", {31'd0, dut_irq[0]}, 32'd1);
        bus_write(3'd3, 32'h004);
        idle(1); check("rise_irq_off", {31'd0, dut_irq[0]}, 32'd0);
        bus_read(3'd3); check("rise_cap_w1c", rdv[0], 32'h001);

        // Falling-only and any-edge instances.
        pin[1] = 10'h3FE; pin[2] = 10'h3FE;
        idle(6);
        bus_read(3'd3); check("fall_cap1", rdv[1], 32'h001); check("any_cap1", rdv[2], 32'h001);
        pin[1] = 10'h3FF; pin[2] = 10'h3FF;
        idle(6);
        bus_read(3'd3); check("fall_cap2", rdv[1], 32'h001); check("any_cap2", rdv[2], 32'h001);

        // Debounce: a 5-cycle glitch is rejected.
        pin[3] = 10'h001;
        idle(5);
        pin[3] = 10'h000;
        idle(12);
        bus_read(3'd0); check("deb_glitch_data", rdv[3], 32'h0);
        bus_read(3'd3); check("deb_glitch_cap", rdv[3], 32'h0);

        // Debounce: a held level lands 8 cycles after the synchronised rise.
        addr = 3'd0; cs = 1'b1; wn = 1'b1;
        pin[3] = 10'h001;
        idle(10); check("deb_not_yet", {31'd0, dut_rd[3][0]}, 32'd0);
        idle(1);  check("deb_landed", {31'd0, dut_rd[3][0]}, 32'd1);
        cs = 1'b0;
        idle(12);
        bus_read(3'd3); check("deb_cap", rdv[3], 32'h001);

        // Set/clear collision on bit 3 of the rising instance.
        pin[0] = 10'h00D;
        idle(6);
        bus_read(3'd3); check("col_pre_cap", rdv[0], 32'h009);
        pin[0] = 10'h005;
        idle(6);
        bus_write(3'd2, 32'h008);
        idle(1); check("col_irq_pre", {31'd0, dut_irq[0]}, 32'd1);
        pin[0] = 10'h00D;
        idle(3);
        bus_write(3'd3, 32'h008);
        check("col_irq_mid", {31'd0, dut_irq[0]}, 32'd1);
        idle(1); check("col_irq_post", {31'd0, dut_irq[0]}, 32'd1);
        bus_read(3'd3); check("col_cap", rdv[0], 32'h009);

        // Bus corner cases.
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_write(3'd5, 32'hFFFF_FFFF);
        bus_read(3'd0); check("ro_data", rdv[0], 32'h00D);
        bus_read(3'd2); check("ro_mask", rdv[0], 32'h008);
        bus_read(3'd1); check("rd_addr1", rdv[0], 32'h0);
        bus_read(3'd6); check("rd_addr6", rdv[2], 32'h0);
        bus_write(3'd2, 32'hFFFF_FFFF);
        bus_read(3'd2); check("mask_width", rdv[0], 32'h3FF);

        // Randomised traffic; inputs hold for several cycles on average so
        // the debounced instance sees both accepted and rejected changes.
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 11) == 0) pin[k] = 10'($urandom_range(0, 1023));
            cs   = ($urandom_range(0, 3) != 0);
            wn   = ($urandom_range(0, 2) != 0);
            addr = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(2, 3)) : 3'($urandom_range(0, 7));
            wd   = $urandom;
            @(negedge clk);
        end
        cs = 1'b0; wn = 1'b1;

        // Async reset in the middle of a debounce window.
        pin[3] = pin[3] ^ 10'h001;
        idle(5);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("arst_irq", {28'd0, dut_irq}, 32'd0);
        check("arst_rd_deb", dut_rd[3], 32'd0);
        pin[0] = 10'h000; pin[1] = 10'h3FF; pin[2] = 10'h3FF; pin[3] = 10'h000;
        idle(3);
        reset_n = 1'b1;
        idle(12);
        bus_read(3'd3);
        for (int k = 0; k < 4; k++) check($sformatf("arst_cap[%0d]", k), rdv[k], 32'h0);
        check("arst_irq_after", {28'd0, dut_irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Avalon-MM slave input PIO: the receive-side companion of the existing output PIO, used for switches and push-buttons.
- Synchronises and debounces a WIDTH-bit external input bus and presents its level on a read register.
- Latches selected edges into a write-1-to-clear edge-capture register.
- Drives a level interrupt to the Nios II when any unmasked captured bit is set.

Parameters:
- WIDTH, 10, number of input bits (1..32).
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before the filtered bit changes; 0 = bypass filter.
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
- RESET_LEVEL, 0, value loaded into synchroniser and filtered registers on reset (all bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  read data.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset: reset_n asynchronous, active-low; clock clk. On reset:
  - sync stages = RESET_LEVEL.
  - filtered = RESET_LEVEL.
  - debounce counters = 0.
  - irq_mask = 0, edge_capture = 0.
  - readdata = 0, irq = 0.
- Synchroniser: two-flop per bit, in_port -> s1 -> s2. No combinational path from in_port.
- Debounce, per bit, when DEBOUNCE_CYCLES > 0:
  - If s2 == filtered: counter resets to 0.
  - Otherwise counter increments. When counter reaches DEBOUNCE_CYCLES-1, filtered <= s2 and counter <= 0.
  - Result: filtered changes exactly DEBOUNCE_CYCLES cycles after s2 first differs, provided s2 holds throughout.
  - Counter width = clog2(DEBOUNCE_CYCLES+1).
  - DEBOUNCE_CYCLES = 0: filtered <= s2 every cycle.
- Edge detect: prev register tracks filtered (reset RESET_LEVEL).
  - rise = filtered & ~prev; fall = ~filtered & prev.
  - edge_evt selected by EDGE_TYPE; any = rise | fall.
- Edge capture: edge_capture[i] sets to 1 on edge_evt[i] and is sticky.
- Register map (word addresses). Write occurs when chipselect && !write_n.
  - 0 DATA: read = filtered, zero-extended. Writes ignored.
  - 2 IRQ_MASK: RW, bits [WIDTH-1:0]; upper bits read 0.
  - 3 EDGE_CAPTURE: read = edge_capture. Write clears each bit i where writedata[i] = 1 (W1C).
  - Addresses 1 and 4-7: read 0, writes ignored.
- Simultaneous edge_evt[i] and W1C of bit i in the same cycle: bit ends at 1 (set wins, no lost edge).
- Read timing:
  - readdata is registered. It updates every cycle from the current address when chipselect = 1, otherwise holds.
  - Read latency = 1 clock: data for an address presented at edge N is valid after edge N+1.
  - A read of EDGE_CAPTURE has no side effect.
- irq: registered, irq <= |(edge_capture & irq_mask).
  - Asserts 1 cycle after the capture bit or mask bit becomes set.
  - Deasserts 1 cycle after clear or mask.
- Total latency from in_port pin change to edge_capture set (bypass mode) = 4 edges: s1, s2, filtered, capture. irq follows one edge later.
- Reset mid-debounce: counter and filtered return to reset values; no capture is generated.

Test Plan:
- Reset values: hold reset_n = 0, in_port = 10'h3FF; release; read addr 0 -> 0x3FF by 4 cycles later. Read addr 2 and addr 3 -> 0. irq = 0 throughout.
- Rising capture, EDGE_TYPE = 0, DEBOUNCE_CYCLES = 0:
  - in_port 0x000 -> 0x005: addr 3 reads 0x005; irq stays 0 (mask 0).
  - Write mask 0x004: irq = 1 one cycle later.
  - W1C 0x004: irq = 0; addr 3 reads 0x001.
- Falling/any edge: EDGE_TYPE = 1, in_port 0x3FF -> 0x3FE -> 0x3FF: capture = 0x001 after the fall only. Repeat with EDGE_TYPE = 2: one capture per transition, still 0x001 (sticky).
- Debounce, DEBOUNCE_CYCLES = 8:
  - Bit 0 glitches high for 5 cycles: DATA stays 0, capture stays 0.
  - Held high 20 cycles: DATA bit 0 = 1 exactly 8 cycles after s2 rises; capture bit 0 set.
- Set/clear collision: force a bit-3 edge in the same cycle as W1C writedata = 0x008 -> capture bit 3 remains 1 and irq (mask 0x008) stays 1.
- Bus corner cases:
  - Write 0xFFFFFFFF to addr 0 and addr 5: no state change.
  - Read addr 1 and addr 6: return 0.
  - Write 0xFFFFFFFF to addr 2: reads back 0x3FF.
  - Async reset asserted mid-debounce clears all registers without a spurious irq.
